// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer driving a shared external 8-bit
// carry-lookahead adder, one byte per cycle, LSB first, with the carry
// chained through r_carry.
// Optional feature macro: CLA_SEQ_OVF_EN enables the signed-overflow flag.
// When it is undefined, o_res_ovf is tied to 0.
//
// state | meaning
// IDLE  | ready for a command (o_cmd_ready=1)
// RUN   | one operand byte per cycle through the external adder
// DONE  | result presented (o_res_valid=1) until consumed
module cla_mp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_sub,
    input  logic [8*NBYTES-1:0]   i_cmd_a,
    input  logic [8*NBYTES-1:0]   i_cmd_b,
    output logic [7:0]            o_add_a,
    output logic [7:0]            o_add_b,
    output logic                  o_add_cin,
    input  logic [7:0]            i_add_sum,
    input  logic                  i_add_cout,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [8*NBYTES-1:0]   o_res_sum,
    output logic                  o_res_carry,
    output logic                  o_res_ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_sum;
    logic            r_res_carry;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic            w_last;
    logic            w_accept;

    assign w_last      = (r_k == K_LAST);
    assign w_accept    = (r_state == IDLE) && i_cmd_valid;
    assign o_cmd_ready = (r_state == IDLE);
    assign o_res_valid = (r_state == DONE);
    assign o_res_sum   = r_sum;
    assign o_res_carry = r_res_carry;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; handshake readiness is a pure state decode above.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_cmd_valid) w_next = RUN;
            RUN:     if (w_last)      w_next = DONE;
            DONE:    if (i_res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Select the current operand byte k.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_k == KW'(i)) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
            end
        end
    end

    // Adder drive: only active in RUN, B pre-inverted for subtract.
    always_comb begin
        o_add_a   = '0;
        o_add_b   = '0;
        o_add_cin = 1'b0;
        if (r_state == RUN) begin
            o_add_a   = w_a_byte;
            o_add_b   = w_b_byte ^ {8{r_sub}};
            o_add_cin = r_carry;
        end
    end

    // Operand capture, byte sequencing and result assembly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_sum       <= '0;
            r_res_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_cmd_a;
            r_b     <= i_cmd_b;
            r_sub   <= i_cmd_sub;
            r_carry <= i_cmd_sub;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (r_k == KW'(i)) r_sum[8*i +: 8] <= i_add_sum;
            end
            r_carry <= i_add_cout;
            if (w_last) begin
                r_k         <= '0;
                r_res_carry <= i_add_cout;
            end else begin
                r_k <= r_k + KW'(1);
            end
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf     = (o_add_a[7] == o_add_b[7]) && (i_add_sum[7] != o_add_a[7]);
    assign o_res_ovf = r_ovf;

    // Signed overflow taken from the top byte only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                         r_ovf <= 1'b0;
        else if ((r_state == RUN) && w_last) r_ovf <= w_ovf;
    end
`else
    assign o_res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer (NBYTES=4) with a behavioural
// model of the external 8-bit adder.
module tb_cla_mp_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sub;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_sum;
    logic        res_carry;
    logic        res_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    cla_mp_sequencer #(.NBYTES(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_sub   (cmd_sub),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .o_add_cin   (add_cin),
        .i_add_sum   (add_sum),
        .i_add_cout  (add_cout),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_sum   (res_sum),
        .o_res_carry (res_carry),
        .o_res_ovf   (res_ovf)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ovf(input logic o);
`ifdef CLA_SEQ_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the accept edge; walks the RUN cycles and checks the result.
    task automatic run_and_check(input vec_t v);
        logic [7:0] ab;
        logic [7:0] bb;
        logic       c;
        logic [8:0] s;
        c = v.sub;
        for (int j = 0; j < 4; j++) begin
            ab = v.a[8*j +: 8];
            bb = v.b[8*j +: 8] ^ {8{v.sub}};
            chk("run_add_a", {24'd0, add_a}, {24'd0, ab});
            chk("run_add_b", {24'd0, add_b}, {24'd0, bb});
            chk("run_add_cin", {31'd0, add_cin}, {31'd0, c});
            chk("run_res_valid", {31'd0, res_valid}, 32'd0);
            chk("run_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            s = {1'b0, ab} + {1'b0, bb} + {8'd0, c};
            c = s[8];
            tick();
        end
        chk("done_res_valid", {31'd0, res_valid}, 32'd1);
        chk("done_res_sum", res_sum, v.sum);
        chk("done_res_carry", {31'd0, res_carry}, {31'd0, v.carry});
        chk("done_res_ovf", {31'd0, res_ovf}, {31'd0, exp_ovf(v.ovf)});
        chk("done_add_a", {24'd0, add_a}, 32'd0);
    endtask

    task automatic issue(input vec_t v);
        cmd_valid = 1'b1;
        cmd_sub   = v.sub;
        cmd_a     = v.a;
        cmd_b     = v.b;
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 32'hDEAD_BEEF;
        cmd_b     = 32'hCAFE_F00D;
    endtask

    initial begin
        vec_t vnew;
        vec_t vbp;
        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vnew    = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        vbp     = '{1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b1, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sub   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_sum", res_sum, 32'd0);
        chk("rst_res_carry", {31'd0, res_carry}, 32'd0);
        chk("rst_res_ovf", {31'd0, res_ovf}, 32'd0);
        chk("rst_add", {15'd0, add_cin, add_a, add_b}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i]);
            run_and_check(vecs[i]);
            tick();
            chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            chk("post_res_valid", {31'd0, res_valid}, 32'd0);
        end

        // Backpressure in DONE with a pending command.
        res_ready = 1'b0;
        issue(vbp);
        run_and_check(vbp);
        cmd_valid = 1'b1;
        cmd_sub   = vnew.sub;
        cmd_a     = vnew.a;
        cmd_b     = vnew.b;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_res_sum", res_sum, vbp.sum);
            chk("bp_res_carry", {31'd0, res_carry}, {31'd0, vbp.carry});
            chk("bp_add_a", {24'd0, add_a}, 32'd0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bp_release_res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        run_and_check(vnew);
        tick();

        // Reset during the second RUN cycle.
        issue(vecs[1]);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_add_a", {24'd0, add_a}, 32'd0);
        chk("midrst_res_sum", res_sum, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_result", {31'd0, res_valid}, 32'd0);
        end
        issue(vnew);
        run_and_check(vnew);
        tick();
        chk("final_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
